wb_trace_buffer: RTL
====================

// Module: wb_trace_buffer
// PURPOSE
//  Downstream of the mips core: captures per-cycle architectural commit events (GRF write,
//  DM store) with their PC and queues them in a FIFO. Drains through a valid/ready trace port
//  so a bench or UART dumper can print "@pc: $r <= d" / "@pc: *a <= d" without stalling the core.
//  Never back-pressures the core. Overflow drops events and is counted.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 2
//  DROP_W  16  width of the saturating drop counter
// PORTS
//  clk          in   1    single clock; all state updates on posedge
//  reset        in   1    synchronous, ACTIVE-LOW: reset==0 at posedge clears all state
//  pc           in   32   PC of the instruction committing this cycle
//  grf_we       in   1    GRF write this cycle
//  grf_addr     in   5    GRF destination register
//  grf_wdata    in   32   GRF write data
//  dm_we        in   1    DM store this cycle
//  dm_addr      in   32   DM byte address
//  dm_wdata     in   32   DM store data
//  trace_valid  out  1    head entry available
//  trace_ready  in   1    consumer accepts head when trace_valid && trace_ready
//  trace_kind   out  1    0 = GRF event, 1 = DM event
//  trace_pc     out  32   head PC
//  trace_addr   out  32   GRF: {27'b0, reg}; DM: byte address
//  trace_data   out  32   written data
//  count        out  $clog2(DEPTH)+1  current occupancy
//  overflow     out  1    sticky: set on first dropped event
//  drop_cnt     out  DROP_W  dropped-event count, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset==0 at posedge): count=0, rd/wr pointers=0, overflow=0, drop_cnt=0;
//    trace_valid=0; trace_kind/pc/addr/data = 0 while empty (outputs masked when empty).
//  - Filtering: grf_we with grf_addr==0 produces no event (not dropped, not counted).
//  - Events per cycle: 0, 1 or 2. When both, GRF entry is ordered ahead of DM entry.
//  - Latency: event presented in cycle N is visible at head (if FIFO was empty) right after
//    edge N, i.e. trace_valid=1 in cycle N+1. Head outputs come straight from storage.
//  - Pop: trace_valid && trace_ready at posedge removes the head. trace_ready ignored when empty.
//  - Free space for this cycle = DEPTH - count + pop. Events are accepted in order while
//    space remains; remaining events are dropped (with 1 slot and 2 events: GRF kept, DM dropped).
//  - Each dropped event: drop_cnt += 1 (saturating; 2 drops in one cycle add 2, clamped),
//    overflow <= 1. Overflow clears only on reset.
//  - count next = count + accepted - pop; never exceeds DEPTH, never below 0.
//  - Pointers are log2(DEPTH) bits and wrap naturally; dual write uses wr_ptr and wr_ptr+1.
//  - Full + pop + 1 event same cycle: both happen, count unchanged, no drop.
//  - Reset asserted mid-drain: entries discarded at that edge; trace_valid=0 next cycle;
//    inputs sampled during reset are ignored.
//  - No state machine beyond FIFO occupancy; purely pointer/counter driven.
// STRUCTURE
//  - Package trace_pkg: KIND_GRF=1'b0, KIND_DM=1'b1, ENTRY_W=97 ({kind,pc,addr,data}),
//    field-offset constants.
//  - Sub-module trace_fifo: DEPTH x ENTRY_W storage, two write ports (push0/push1) and one read
//    head, count output. wb_trace_buffer holds event packing, filter, space/drop logic, counters.
// TESTING
//  - Reset: hold reset=0 two cycles with grf_we=1 -> trace_valid=0, count=0, drop_cnt=0 after.
//  - Single GRF: pc=0x3000, $8<=0x1234, ready=1 -> next cycle valid=1, kind=0, addr=8,
//    data=0x1234; popped same cycle, count returns 0.
//  - Dual event: grf $9<=5 and dm *0x10<=7 same cycle, ready=0 -> count=2, head kind=0 addr=9;
//    after one pop head kind=1 addr=0x10 data=7.
//  - $0 filter: grf_we=1 addr=0 -> count stays 0, drop_cnt stays 0.
//  - Overflow: ready=0, 9 GRF events with DEPTH=8 -> count=8, overflow=1, drop_cnt=1; then
//    count=7 plus dual event -> GRF kept, DM dropped, drop_cnt=2.
//  - Full+pop+push: count=8, ready=1, one event -> count stays 8, drop_cnt unchanged,
//    FIFO order preserved over full drain (pc values strictly in issue order).

Source files
------------

// File: rtl/trace_pkg.sv
// Shared encodings and entry layout for the commit-trace buffer.
// An entry is packed as {kind, pc, addr, data}, with data in the low bits.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  localparam int FIELD_W  = 32;
  localparam int OFF_DATA = 0;
  localparam int OFF_ADDR = OFF_DATA + FIELD_W;
  localparam int OFF_PC   = OFF_ADDR + FIELD_W;
  localparam int OFF_KIND = OFF_PC + FIELD_W;
  localparam int ENTRY_W  = OFF_KIND + 1;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic               kind,
    input logic [FIELD_W-1:0] pc,
    input logic [FIELD_W-1:0] addr,
    input logic [FIELD_W-1:0] data
  );
    logic [ENTRY_W-1:0] e;
    e                      = '0;
    e[OFF_KIND]            = kind;
    e[OFF_PC +: FIELD_W]   = pc;
    e[OFF_ADDR +: FIELD_W] = addr;
    e[OFF_DATA +: FIELD_W] = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Valid/ready trace drain port. The master side is the buffer and the slave side is the
// consumer (a bench monitor or a UART dumper).
interface wb_trace_buffer_if;

  logic        trace_valid;
  logic        trace_ready;
  logic        trace_kind;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  modport master (
    output trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
    output trace_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Circular FIFO with two ordered write ports and one read head. The upstream logic raises
// push1 only together with push0, so the two new entries always land in adjacent slots.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic [W-1:0]             din0,
  input  logic                     push1,
  input  logic [W-1:0]             din1,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Storage is not reset; the head is masked by the parent while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= din0;
    if (push1) mem[wr_ptr + PTR_ONE] <= din1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt    <= cnt + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures per-cycle GRF-write and DM-store commit events into a FIFO. The FIFO drains over a
// valid/ready port and never stalls the core. Events that find no room are dropped and counted.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc,
  input  logic                    grf_we,
  input  logic [4:0]              grf_addr,
  input  logic [31:0]             grf_wdata,
  input  logic                    dm_we,
  input  logic [31:0]             dm_addr,
  input  logic [31:0]             dm_wdata,
  wb_trace_buffer_if.master       tr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [DROP_W-1:0] sat_add(
    input logic [DROP_W-1:0] a,
    input logic [1:0]        b
  );
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  logic [CW-1:0]      cnt;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] grf_entry;
  logic [ENTRY_W-1:0] dm_entry;
  logic               valid;
  logic               pop;
  logic               grf_evt;
  logic               dm_evt;
  logic               any_evt;
  logic               both_evt;
  logic [CW-1:0]      space;
  logic               acc0;
  logic               acc1;
  logic [1:0]         n_drop;

  // Writes to $0 are architecturally invisible; inputs during reset are ignored.
  assign grf_evt  = reset && grf_we && (grf_addr != 5'd0);
  assign dm_evt   = reset && dm_we;
  assign any_evt  = grf_evt || dm_evt;
  assign both_evt = grf_evt && dm_evt;

  assign valid = (cnt != '0);
  assign pop   = valid && tr.trace_ready;

  // A slot freed by this cycle's pop can be reused by this cycle's event.
  assign space = CW'(DEPTH) - cnt + CW'(pop);
  assign acc0  = any_evt && (space != '0);
  assign acc1  = both_evt && (space >= CW'(2));
  assign n_drop = 2'(grf_evt) + 2'(dm_evt) - 2'(acc0) - 2'(acc1);

  assign grf_entry = pack_entry(KIND_GRF, pc, {27'b0, grf_addr}, grf_wdata);
  assign dm_entry  = pack_entry(KIND_DM, pc, dm_addr, dm_wdata);

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (acc0),
    .din0  (grf_evt ? grf_entry : dm_entry),
    .push1 (acc1),
    .din1  (dm_entry),
    .pop   (pop),
    .head  (head),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (n_drop != 2'd0) begin
      drop_cnt <= sat_add(drop_cnt, n_drop);
      overflow <= 1'b1;
    end
  end

  assign tr.trace_valid = valid;
  assign tr.trace_kind  = valid & head[OFF_KIND];
  assign tr.trace_pc    = valid ? head[OFF_PC +: FIELD_W]   : '0;
  assign tr.trace_addr  = valid ? head[OFF_ADDR +: FIELD_W] : '0;
  assign tr.trace_data  = valid ? head[OFF_DATA +: FIELD_W] : '0;
  assign count          = cnt;

endmodule
